fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the single write port of fifo_sync among N_REQ requesters using round-robin arbitration.
//   Each requester presents a valid/data pair and sees a one-cycle grant when its word is written.
//   The block sits directly in front of fifo_sync and drives its w_en and data_in.
//   It watches fifo_full and never writes into a full FIFO.
// PARAMETERS
//   DATA_WIDTH  8  width of each requester word and of the FIFO data
//   N_REQ       4  number of requesters (2..16)
//   BURST_LEN   4  maximum consecutive grants to one requester; used only with FIFO_WR_ARB_BURST_EN
// PORTS
//   clk_i        in   1                 clock, rising edge
//   reset_i      in   1                 synchronous reset, active-high
//   req_i        in   N_REQ             per-requester valid; bit k = requester k has a word
//   data_i       in   N_REQ*DATA_WIDTH  requester k word at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o        out  N_REQ             one-hot; bit k high = requester k word is written at this edge
//   gnt_id_o     out  clog2(N_REQ)      binary index of granted requester; valid when fifo_w_en_o=1
//   fifo_full_i  in   1                 from fifo_sync fifo_full
//   fifo_w_en_o  out  1                 to fifo_sync w_en
//   fifo_data_o  out  DATA_WIDTH        to fifo_sync data_in; equals data_i slice of granted requester
// BEHAVIOUR
//   - Handshake: req_i[k] is the valid signal and gnt_o[k] is the ready signal. A transfer occurs on
//     a rising edge where both are high. The requester holds req_i[k] and its data stable until that edge.
//   - Grant path is combinational from req_i, fifo_full_i and state, so latency is 0 cycles.
//     The FIFO captures the word at the same edge. State registers: last_id and, with the macro, burst_cnt/locked.
//   - fifo_w_en_o = |gnt_o. gnt_o is one-hot or all zero.
//   - fifo_data_o shows the granted slice. When there is no grant it shows the slice selected by last_id;
//     this is a don't-care, but it must not be X in simulation.
//   - Round-robin: the search starts at (last_id+1) mod N_REQ and runs upward with wrap-around.
//     The first requester with req_i high wins. last_id updates to the winner on every transfer edge.
//   - Full stall: when fifo_full_i=1, gnt_o=0 and fifo_w_en_o=0. No state changes, so priority order is kept.
//   - No requests: gnt_o=0 and fifo_w_en_o=0. last_id holds.
//   - Reset: while reset_i=1, gnt_o=0 and fifo_w_en_o=0 (outputs gated).
//     At the next edge last_id<=N_REQ-1 (requester 0 has first priority), locked<=0 and burst_cnt<=0.
//   - Reset mid-burst: the lock is discarded. The first grant after reset follows normal order from requester 0.
//   - gnt_id_o is the encoded index of gnt_o. It is 0 when there is no grant.
// CONFIGURATION
//   FIFO_WR_ARB_BURST_EN defined:
//     - A transfer from an unlocked arbiter sets locked=1 and burst_cnt=1.
//     - While locked and req_i[last_id]=1, the grant stays on last_id regardless of other requests.
//       burst_cnt increments on each transfer.
//     - When burst_cnt reaches BURST_LEN, the lock releases after that transfer.
//       The next grant re-arbitrates from last_id+1.
//     - If the locked requester drops req, the lock releases combinationally in that cycle.
//       Re-arbitration from last_id+1 happens in the same cycle.
//     - A full stall freezes burst_cnt and locked.
//   FIFO_WR_ARB_BURST_EN undefined:
//     - Pure round-robin with one word per grant. BURST_LEN is ignored and no lock logic is built.
// TESTING
//   T1: N_REQ=4, req_i=4'b1111 constant, fifo_full_i=0, no macro.
//       -> gnt_id_o = 0,1,2,3,0,1... and fifo_w_en_o=1 every cycle.
//       -> FIFO contents match each requester's data in that order.
//   T2: req_i=4'b0110, fifo_full_i=1 for 3 cycles, then 0.
//       -> gnt_o=0 for 3 cycles, then gnt_id_o=1, then 2, then 1.
//   T3: req_i=4'b1000 held 5 cycles.
//       -> gnt_o=4'b1000 every cycle, 5 words written.
//   T4: FIFO_WR_ARB_BURST_EN, BURST_LEN=4, req_i=4'b1111.
//       -> gnt_id_o = 0,0,0,0,1,1,1,1,2...
//   T4b: same configuration, req_i[0] drops after 2 grants.
//       -> third cycle grants 1; requester 1 then gets a full burst of 4.
//   T5: reset_i=1 for 1 cycle in the middle of requester 2's burst, req_i=4'b1111.
//       -> gnt_o=0 during reset; the first grant afterwards is id 0.
//   T6: req_i=0 for 10 cycles, then 4'b0100.
//       -> fifo_w_en_o=0 while idle; the first write is from id 2 with the correct data.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo_sync write port among N_REQ requesters.
// Optional burst locking is enabled by defining FIFO_WR_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int BURST_LEN  = 4,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [IDW-1:0]              gnt_id_o,
  input  logic                        fifo_full_i,
  output logic                        fifo_w_en_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  logic [IDW-1:0] last_id_q, last_id_d;

  logic [IDW-1:0] start_id;
  logic [IDW-1:0] rr_id;
  logic           rr_hit;
  logic [IDW-1:0] win_id;
  logic           win_hit;
  logic           hold;
  logic           fire;
  logic [IDW-1:0] sel_id;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] BLEN_W = CW'(BURST_LEN);

  logic          locked_q, locked_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  assign hold    = locked_q && req_i[last_id_q];
  assign cnt_inc = cnt_q + CW'(1);
`else
  assign hold = 1'b0;
`endif

  // Round-robin search starting one past the last winner, with wrap.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    start_id = (last_id_q == LAST_ID) ? '0 : last_id_q + IDW'(1);
    rr_hit   = 1'b0;
    rr_id    = '0;
    sum      = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, start_id} + (IDW+1)'(i);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      cand = sum[IDW-1:0];
      if (!rr_hit && req_i[cand]) begin
        rr_hit = 1'b1;
        rr_id  = cand;
      end
    end
  end

  // Pick winner (locked owner first) and gate by full/reset.
  always_comb begin
    win_id  = hold ? last_id_q : rr_id;
    win_hit = hold | rr_hit;
    fire    = win_hit && !fifo_full_i && !reset_i;
    sel_id  = fire ? win_id : last_id_q;
  end

  // Grant vector and encoded id; both zero when nothing is written.
  always_comb begin
    gnt_o       = '0;
    gnt_id_o    = fire ? win_id : '0;
    fifo_w_en_o = fire;
    for (int k = 0; k < N_REQ; k++) begin
      gnt_o[k] = fire && (win_id == IDW'(k));
    end
  end

  // Data mux: granted slice, or last winner's slice when idle.
  always_comb begin
    fifo_data_o = data_i[DATA_WIDTH-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_id == IDW'(k)) begin
        fifo_data_o = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state for the round-robin pointer.
  always_comb begin
    last_id_d = last_id_q;
    if (fire) begin
      last_id_d = win_id;
    end
  end

`ifdef FIFO_WR_ARB_BURST_EN
  // Burst lock: start on a fresh grant, count, release at BURST_LEN or on drop.
  always_comb begin
    locked_d = locked_q;
    cnt_d    = cnt_q;
    if (fire) begin
      if (hold) begin
        if (cnt_inc >= BLEN_W) begin
          locked_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (BURST_LEN > 1) begin
        locked_d = 1'b1;
        cnt_d    = CW'(1);
      end else begin
        locked_d = 1'b0;
        cnt_d    = '0;
      end
    end else if (!fifo_full_i && !reset_i && locked_q && !hold) begin
      locked_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // Lock state registers; reset discards any burst in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  // Pointer register; reset gives requester 0 first priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_id_q <= LAST_ID;
    end else begin
      last_id_q <= last_id_d;
    end
  end

endmodule
